// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcode map, FSM state
// encoding, jump encodings, PSW bit positions and the decoded op-class bundle.
package multicycle_ctrl_pkg;

  // Primary opcodes (IR[15:11])
  localparam logic [4:0] OP_SYS   = 5'b00000;
  localparam logic [4:0] OP_LHI   = 5'b00001;
  localparam logic [4:0] OP_LLI   = 5'b00010;
  localparam logic [4:0] OP_LDR   = 5'b00011;
  localparam logic [4:0] OP_STR   = 5'b00100;
  localparam logic [4:0] OP_ALU   = 5'b00101;
  localparam logic [4:0] OP_ALUI  = 5'b00110;
  localparam logic [4:0] OP_CMP   = 5'b00111;
  localparam logic [4:0] OP_B     = 5'b01000;
  localparam logic [4:0] OP_BCOND = 5'b01001;
  localparam logic [4:0] OP_JR    = 5'b01010;

  // SYS function codes (IR[1:0])
  localparam logic [1:0] FUNC_OUTR = 2'b00;
  localparam logic [1:0] FUNC_HLT  = 2'b01;

  // BCOND condition codes (IR[1:0])
  localparam logic [1:0] BC_Z  = 2'b00;
  localparam logic [1:0] BC_NZ = 2'b01;
  localparam logic [1:0] BC_C  = 2'b10;
  localparam logic [1:0] BC_N  = 2'b11;

  // Jump mux encodings
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_IMM  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;

  // PSW bit indices
  localparam int unsigned PSW_N = 32'd2;
  localparam int unsigned PSW_Z = 32'd1;
  localparam int unsigned PSW_C = 32'd0;

  // Controller phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Op-class bundle produced by the decoder; the FSM looks only at this
  typedef struct packed {
    logic       is_load;    // LDR
    logic       is_store;   // STR
    logic       is_li;      // LHI or LLI
    logic       is_li_hi;   // LHI (high-byte immediate)
    logic       is_alu;     // ALU, ALUI, CMP
    logic       use_imm;    // B operand is the immediate
    logic       reads_rb;   // RB read address comes from the RB field
    logic       alu_sub;    // ALU subtracts
    logic       writes_rf;  // result written back to the register file
    logic       sets_flag;  // PSW updated in EXEC
    logic       is_branch;  // B, BCOND, JR
    logic       is_bcond;   // conditional branch
    logic [1:0] jump_kind;  // JMP_* for the PC mux
    logic       is_sys;     // OUTR or HLT
    logic       is_halt;    // HLT
    logic       illegal;    // opcode/func not in the map
  } op_class_t;

  // Evaluate a BCOND condition against the PSW flags
  function automatic logic bcond_taken(input logic [1:0] func, input logic [2:0] nzc);
    logic taken;
    case (func)
      BC_Z:    taken = nzc[PSW_Z];
      BC_NZ:   taken = ~nzc[PSW_Z];
      BC_C:    taken = nzc[PSW_C];
      BC_N:    taken = nzc[PSW_N];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: (opcode, func) -> op-class bundle.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] func,
  output op_class_t  op_class
);

  op_class_t class_s;

  // Map each opcode to its class flags; anything unmapped is illegal
  always_comb begin
    class_s = '0;
    case (opcode)
      OP_SYS: begin
        case (func)
          FUNC_OUTR: class_s.is_sys = 1'b1;
          FUNC_HLT: begin
            class_s.is_sys  = 1'b1;
            class_s.is_halt = 1'b1;
          end
          default: class_s.illegal = 1'b1;
        endcase
      end
      OP_LHI: begin
        class_s.is_li     = 1'b1;
        class_s.is_li_hi  = 1'b1;
        class_s.writes_rf = 1'b1;
      end
      OP_LLI: begin
        class_s.is_li     = 1'b1;
        class_s.writes_rf = 1'b1;
      end
      OP_LDR: begin
        class_s.is_load   = 1'b1;
        class_s.use_imm   = 1'b1;
        class_s.writes_rf = 1'b1;
      end
      OP_STR: begin
        class_s.is_store = 1'b1;
        class_s.use_imm  = 1'b1;
        class_s.reads_rb = 1'b1;
      end
      OP_ALU: begin
        class_s.is_alu    = 1'b1;
        class_s.reads_rb  = 1'b1;
        class_s.writes_rf = 1'b1;
        class_s.sets_flag = 1'b1;
        class_s.alu_sub   = func[0];
      end
      OP_ALUI: begin
        class_s.is_alu    = 1'b1;
        class_s.use_imm   = 1'b1;
        class_s.writes_rf = 1'b1;
        class_s.sets_flag = 1'b1;
      end
      OP_CMP: begin
        class_s.is_alu    = 1'b1;
        class_s.reads_rb  = 1'b1;
        class_s.sets_flag = 1'b1;
        class_s.alu_sub   = func[0];
      end
      OP_B: begin
        class_s.is_branch = 1'b1;
        class_s.jump_kind = JMP_IMM;
      end
      OP_BCOND: begin
        class_s.is_branch = 1'b1;
        class_s.is_bcond  = 1'b1;
        class_s.jump_kind = JMP_NONE;
      end
      OP_JR: begin
        class_s.is_branch = 1'b1;
        class_s.jump_kind = JMP_REG;
      end
      default: class_s.illegal = 1'b1;
    endcase
  end

  assign op_class = class_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM controller for the 16-bit RISC core. Sequences
// FETCH/DECODE/EXEC/MEM/WB and drives every datapath strobe.
// Strobes are decoded from the state register plus the op class latched at
// the DECODE edge. DECODE itself must use the live opcode, because the IR is
// only loaded on the FETCH->DECODE edge. The async reset forces the state
// register to IDLE, so every strobe drops in the same instant.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b1
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [4:0] opcode,
  input  logic [1:0] ALUopcode,
  input  logic [2:0] PSW_NZC,
  output logic       Buff_MEMIns,
  output logic       MEMresource,
  output logic       WE_MEM,
  output logic       ALUorNot,
  output logic       LIorMOV,
  output logic       WBresource,
  output logic       RBresource,
  output logic       oprandB,
  output logic       LI,
  output logic       PCplus1orWB,
  output logic       WE_RF,
  output logic       Flag,
  output logic       ALUop,
  output logic       Buff_PSW,
  output logic [1:0] Jump,
  output logic       Branch,
  output logic       Buff_PC,
  output logic       done
);

  state_t    state_r;
  op_class_t op_r;
  logic [1:0] func_r;
  op_class_t dec_s;
  logic      halt_now_s;
  logic      skip_now_s;

  multicycle_ctrl_decode u_decode (
    .opcode   (opcode),
    .func     (ALUopcode),
    .op_class (dec_s)
  );

  // An illegal opcode either halts or is skipped like OUTR
  assign halt_now_s = dec_s.is_halt | (dec_s.illegal & ILLEGAL_HALTS);
  assign skip_now_s = (dec_s.is_sys & ~dec_s.is_halt) | (dec_s.illegal & ~ILLEGAL_HALTS);

  // Phase sequencer; latches the op class and func field at the DECODE edge
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      op_r    <= '0;
      func_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE:   state_r <= ST_FETCH;
        ST_FETCH:  state_r <= ST_DECODE;
        ST_DECODE: begin
          op_r   <= dec_s;
          func_r <= ALUopcode;
          if (halt_now_s) begin
            state_r <= ST_HALT;
          end else if (skip_now_s) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_r.is_branch) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_MEM:  state_r <= ST_WB;
        ST_WB:   state_r <= ST_FETCH;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  logic       memins_s, memres_s, we_mem_s, aluornot_s, liormov_s, wbres_s;
  logic       rbres_s, oprandb_s, li_s, pcp1_s, we_rf_s, flag_s, aluop_s;
  logic       buff_psw_s, branch_s, buff_pc_s, done_s;
  logic [1:0] jump_s;

  // Moore strobe decode; everything not named for a phase stays 0
  always_comb begin
    memins_s   = 1'b0;
    memres_s   = 1'b0;
    we_mem_s   = 1'b0;
    aluornot_s = 1'b0;
    liormov_s  = 1'b0;
    wbres_s    = 1'b0;
    rbres_s    = 1'b0;
    oprandb_s  = 1'b0;
    li_s       = 1'b0;
    pcp1_s     = 1'b0;
    we_rf_s    = 1'b0;
    flag_s     = 1'b0;
    aluop_s    = 1'b0;
    buff_psw_s = 1'b0;
    jump_s     = JMP_NONE;
    branch_s   = 1'b0;
    buff_pc_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_FETCH: memins_s = 1'b1;
      ST_DECODE: begin
        rbres_s   = dec_s.reads_rb;
        oprandb_s = dec_s.use_imm;
        li_s      = dec_s.is_li_hi;
        buff_pc_s = dec_s.is_sys | dec_s.illegal;
      end
      ST_EXEC: begin
        flag_s     = op_r.sets_flag;
        buff_psw_s = op_r.sets_flag;
        aluop_s    = op_r.sets_flag & op_r.alu_sub;
        jump_s     = op_r.is_branch ? op_r.jump_kind : JMP_NONE;
        // PSW is sampled live here; a preceding CMP wrote it several cycles ago
        branch_s   = op_r.is_bcond & bcond_taken(func_r, PSW_NZC);
        buff_pc_s  = op_r.is_branch;
      end
      ST_MEM: begin
        memres_s   = op_r.is_load | op_r.is_store;
        we_mem_s   = op_r.is_store;
        aluornot_s = op_r.is_li;
        liormov_s  = 1'b0;
      end
      ST_WB: begin
        buff_pc_s = 1'b1;
        we_rf_s   = op_r.writes_rf;
        pcp1_s    = op_r.writes_rf;
        wbres_s   = op_r.writes_rf & op_r.is_load;
      end
      ST_HALT: done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // Fields carried in the latched bundle that later phases do not consult
  logic unused_op_s;
  assign unused_op_s = ^{op_r.is_alu, op_r.use_imm, op_r.reads_rb, op_r.is_li_hi,
                         op_r.is_sys, op_r.is_halt, op_r.illegal};

  assign Buff_MEMIns = memins_s;
  assign MEMresource = memres_s;
  assign WE_MEM      = we_mem_s;
  assign ALUorNot    = aluornot_s;
  assign LIorMOV     = liormov_s;
  assign WBresource  = wbres_s;
  assign RBresource  = rbres_s;
  assign oprandB     = oprandb_s;
  assign LI          = li_s;
  assign PCplus1orWB = pcp1_s;
  assign WE_RF       = we_rf_s;
  assign Flag        = flag_s;
  assign ALUop       = aluop_s;
  assign Buff_PSW    = buff_psw_s;
  assign Jump        = jump_s;
  assign Branch      = branch_s;
  assign Buff_PC     = buff_pc_s;
  assign done        = done_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Two instances share all stimulus:
// u_h halts on an illegal opcode, u_n skips it. Each cycle the full strobe
// vector is compared against a hand-built expected mask.
module tb_multicycle_ctrl;

  // Strobe vector bit masks: {MEMIns,MEMres,WE_MEM,ALUorNot,LIorMOV,WBres,
  // RBres,oprandB,LI,PCp1,WE_RF,Flag,ALUop,PSW,Jump[1:0],Branch,Buff_PC,done}
  localparam logic [18:0] M_MEMINS = 19'h40000;
  localparam logic [18:0] M_MEMRES = 19'h20000;
  localparam logic [18:0] M_WEMEM  = 19'h10000;
  localparam logic [18:0] M_ALUNOT = 19'h08000;
  localparam logic [18:0] M_WBRES  = 19'h02000;
  localparam logic [18:0] M_RBRES  = 19'h01000;
  localparam logic [18:0] M_OPB    = 19'h00800;
  localparam logic [18:0] M_LI     = 19'h00400;
  localparam logic [18:0] M_PCP1   = 19'h00200;
  localparam logic [18:0] M_WERF   = 19'h00100;
  localparam logic [18:0] M_FLAG   = 19'h00080;
  localparam logic [18:0] M_ALUOP  = 19'h00040;
  localparam logic [18:0] M_PSW    = 19'h00020;
  localparam logic [18:0] M_JREG   = 19'h00010;
  localparam logic [18:0] M_JIMM   = 19'h00008;
  localparam logic [18:0] M_BRANCH = 19'h00004;
  localparam logic [18:0] M_BPC    = 19'h00002;
  localparam logic [18:0] M_DONE   = 19'h00001;
  localparam logic [18:0] M_NONE   = 19'h00000;

  logic       clk = 1'b0;
  logic       Rst = 1'b0;
  logic [4:0] opcode = 5'b00000;
  logic [1:0] ALUopcode = 2'b00;
  logic [2:0] PSW_NZC = 3'b000;

  logic       h_memins, h_memres, h_wemem, h_alunot, h_liormov, h_wbres, h_rbres;
  logic       h_opb, h_li, h_pcp1, h_werf, h_flag, h_aluop, h_psw, h_branch, h_bpc, h_done;
  logic [1:0] h_jump;
  logic       n_memins, n_memres, n_wemem, n_alunot, n_liormov, n_wbres, n_rbres;
  logic       n_opb, n_li, n_pcp1, n_werf, n_flag, n_aluop, n_psw, n_branch, n_bpc, n_done;
  logic [1:0] n_jump;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ILLEGAL_HALTS(1'b1)) u_h (
    .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
    .Buff_MEMIns(h_memins), .MEMresource(h_memres), .WE_MEM(h_wemem), .ALUorNot(h_alunot),
    .LIorMOV(h_liormov), .WBresource(h_wbres), .RBresource(h_rbres), .oprandB(h_opb),
    .LI(h_li), .PCplus1orWB(h_pcp1), .WE_RF(h_werf), .Flag(h_flag), .ALUop(h_aluop),
    .Buff_PSW(h_psw), .Jump(h_jump), .Branch(h_branch), .Buff_PC(h_bpc), .done(h_done)
  );

  multicycle_ctrl #(.ILLEGAL_HALTS(1'b0)) u_n (
    .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
    .Buff_MEMIns(n_memins), .MEMresource(n_memres), .WE_MEM(n_wemem), .ALUorNot(n_alunot),
    .LIorMOV(n_liormov), .WBresource(n_wbres), .RBresource(n_rbres), .oprandB(n_opb),
    .LI(n_li), .PCplus1orWB(n_pcp1), .WE_RF(n_werf), .Flag(n_flag), .ALUop(n_aluop),
    .Buff_PSW(n_psw), .Jump(n_jump), .Branch(n_branch), .Buff_PC(n_bpc), .done(n_done)
  );

  logic [18:0] obs_h, obs_n;
  assign obs_h = {h_memins, h_memres, h_wemem, h_alunot, h_liormov, h_wbres, h_rbres, h_opb,
                  h_li, h_pcp1, h_werf, h_flag, h_aluop, h_psw, h_jump, h_branch, h_bpc, h_done};
  assign obs_n = {n_memins, n_memres, n_wemem, n_alunot, n_liormov, n_wbres, n_rbres, n_opb,
                  n_li, n_pcp1, n_werf, n_flag, n_aluop, n_psw, n_jump, n_branch, n_bpc, n_done};

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [18:0] exp);
    chk({tag, "/halt"}, obs_h, exp);
    chk({tag, "/nop"}, obs_n, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // In FETCH: check it, present the next instruction word, advance to DECODE
  task automatic fetch_issue(input string tag, input logic [4:0] op, input logic [1:0] f);
    chk_both({tag, "_fetch"}, M_MEMINS);
    opcode    = op;
    ALUopcode = f;
    step();
  endtask

  initial begin
    // Reset held, then released away from the edge
    step(); step();
    chk_both("reset_idle", M_NONE);
    Rst = 1'b1;
    chk_both("idle_after_release", M_NONE);
    step();

    // LLI: 5 cycles
    fetch_issue("lli", 5'b00010, 2'b00);
    chk_both("lli_decode", M_NONE);               step();
    chk_both("lli_exec", M_NONE);                 step();
    chk_both("lli_mem", M_ALUNOT);                step();
    chk_both("lli_wb", M_WERF | M_PCP1 | M_BPC);  step();

    // LDR: next FETCH on the 6th edge
    fetch_issue("ldr", 5'b00011, 2'b00);
    chk_both("ldr_decode", M_OPB);                step();
    chk_both("ldr_exec", M_NONE);                 step();
    chk_both("ldr_mem", M_MEMRES);                step();
    chk_both("ldr_wb", M_WBRES | M_WERF | M_PCP1 | M_BPC); step();

    // CMP (subtract), PSW becomes Z=1 after its EXEC edge
    fetch_issue("cmp1", 5'b00111, 2'b01);
    chk_both("cmp1_decode", M_RBRES);             step();
    chk_both("cmp1_exec", M_FLAG | M_PSW | M_ALUOP); step();
    PSW_NZC = 3'b010;
    chk_both("cmp1_mem", M_NONE);                 step();
    chk_both("cmp1_wb", M_BPC);                   step();

    // BCOND Z=1: taken
    fetch_issue("bz_taken", 5'b01001, 2'b00);
    chk_both("bz_taken_decode", M_NONE);          step();
    chk_both("bz_taken_exec", M_BRANCH | M_BPC);  step();

    // CMP again, PSW now all clear; BCOND Z=1 not taken
    fetch_issue("cmp2", 5'b00111, 2'b01);
    chk_both("cmp2_decode", M_RBRES);             step();
    chk_both("cmp2_exec", M_FLAG | M_PSW | M_ALUOP); step();
    PSW_NZC = 3'b000;
    chk_both("cmp2_mem", M_NONE);                 step();
    chk_both("cmp2_wb", M_BPC);                   step();
    fetch_issue("bz_nt", 5'b01001, 2'b00);
    chk_both("bz_nt_decode", M_NONE);             step();
    chk_both("bz_nt_exec", M_BPC);                step();

    // BCOND Z=0 with Z clear: taken
    fetch_issue("bnz", 5'b01001, 2'b01);
    step();
    chk_both("bnz_exec", M_BRANCH | M_BPC);       step();

    // B and JR
    fetch_issue("b", 5'b01000, 2'b00);
    step();
    chk_both("b_exec", M_JIMM | M_BPC);           step();
    fetch_issue("jr", 5'b01010, 2'b00);
    step();
    chk_both("jr_exec", M_JREG | M_BPC);          step();

    // ALU add, ALUI, LHI
    fetch_issue("alu", 5'b00101, 2'b00);
    chk_both("alu_decode", M_RBRES);              step();
    chk_both("alu_exec", M_FLAG | M_PSW);         step();
    chk_both("alu_mem", M_NONE);                  step();
    chk_both("alu_wb", M_WERF | M_PCP1 | M_BPC);  step();
    fetch_issue("alui", 5'b00110, 2'b01);
    chk_both("alui_decode", M_OPB);               step();
    chk_both("alui_exec", M_FLAG | M_PSW);        step();
    step();
    chk_both("alui_wb", M_WERF | M_PCP1 | M_BPC); step();
    fetch_issue("lhi", 5'b00001, 2'b00);
    chk_both("lhi_decode", M_LI);                 step();
    step();
    chk_both("lhi_mem", M_ALUNOT);                step();
    chk_both("lhi_wb", M_WERF | M_PCP1 | M_BPC);  step();

    // OUTR: 2 cycles
    fetch_issue("outr", 5'b00000, 2'b00);
    chk_both("outr_decode", M_BPC);               step();

    // STR with reset asserted in its MEM cycle
    fetch_issue("str", 5'b00100, 2'b00);
    chk_both("str_decode", M_RBRES | M_OPB);      step();
    chk_both("str_exec", M_NONE);                 step();
    chk_both("str_mem", M_MEMRES | M_WEMEM);
    #2 Rst = 1'b0;
    #1 chk_both("str_async_reset", M_NONE);
    step();
    chk_both("reset_hold", M_NONE);
    Rst = 1'b1;
    step();
    chk_both("resume_fetch", M_MEMINS);

    // Illegal opcode: u_h halts, u_n skips
    fetch_issue("ill", 5'b11111, 2'b00);
    chk_both("ill_decode", M_BPC);                step();
    chk("ill_halt_done", obs_h, M_DONE);
    chk("ill_nop_fetch", obs_n, M_MEMINS);
    Rst = 1'b0;
    #1 chk_both("ill_reset", M_NONE);
    step();
    Rst = 1'b1;
    step();

    // OUTR then HLT; done sticky for 20 cycles
    fetch_issue("outr2", 5'b00000, 2'b00);
    chk_both("outr2_decode", M_BPC);              step();
    fetch_issue("hlt", 5'b00000, 2'b01);
    chk_both("hlt_decode", M_BPC);                step();
    opcode = 5'b00010;
    for (int i = 0; i < 20; i++) begin
      chk_both("hlt_done", M_DONE);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle FSM controller for the 16-bit RISC core.
- Consumes the instruction fields and PSW flags from the datapath (opcode, ALUopcode, PSW_NZC).
- Generates every datapath control strobe, one phase per cycle: FETCH, DECODE, EXEC, MEM, WB.
- Sits beside the datapath in the top level and replaces hand-driven control sequences; asserts done on HLT.

Parameters:
- ILLEGAL_HALTS, 1: 1 = an illegal opcode enters HALT; 0 = it executes as a NOP (PC+1).

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- opcode  in  5  IR[15:11]; valid from DECODE onward.
- ALUopcode  in  2  IR[1:0] function field.
- PSW_NZC  in  3  [2]=N, [1]=Z, [0]=C; registered PSW.
- Buff_MEMIns  out  1  IR load enable.
- MEMresource  out  1  memory address select: 0=PC, 1=ALU result.
- WE_MEM  out  1  memory write enable.
- ALUorNot  out  1  result-path select: 1 = LI/MOV path, 0 = ALU.
- LIorMOV  out  1  0 = immediate, 1 = register move.
- WBresource  out  1  write-back source: 0 = ALU/LI path, 1 = memory data.
- RBresource  out  1  RB read-address select.
- oprandB  out  1  ALU B-operand: 1 = immediate.
- LI  out  1  1 = high-byte immediate (LHI), 0 = low-byte.
- PCplus1orWB  out  1  RF write-data select.
- WE_RF  out  1  register file write enable.
- Flag  out  1  ALU flag-update enable.
- ALUop  out  1  0 = add, 1 = subtract.
- Buff_PSW  out  1  PSW load enable.
- Jump  out  2  00 = none, 01 = PC+imm, 10 = register.
- Branch  out  1  take PC-relative branch.
- Buff_PC  out  1  PC load enable.
- done  out  1  HALT reached; sticky.

Behaviour:
- Opcode map (fixed):
  - SYS 00000: func 00 OUTR, func 01 HLT, func 1x illegal.
  - LHI 00001; LLI 00010; LDR 00011; STR 00100; ALU 00101 (ALUop=func[0]); ALUI 00110; CMP 00111.
  - B 01000; BCOND 01001 (func 00 Z=1, 01 Z=0, 10 C=1, 11 N=1); JR 01010.
  - All other opcodes illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoded 3-bit; one-hot allowed.
- Reset:
  - Rst=0 forces IDLE immediately (async), including mid-instruction.
  - In IDLE all outputs are 0 and done=0; no partial WE_RF/WE_MEM is ever issued.
  - IDLE -> FETCH on the first clk edge after Rst deasserts.
- Outputs are Moore: decoded from the state register and the opcode/func latched at the DECODE edge. Unasserted outputs are driven 0, never X.
- FETCH: Buff_MEMIns=1, MEMresource=0. -> DECODE.
- DECODE: latch opcode and func.
  - Read selects: RBresource=1 for STR/ALU/CMP; oprandB=1 for LDR/STR/ALUI; LI=1 for LHI.
  - OUTR / illegal with ILLEGAL_HALTS=0: Buff_PC=1 -> FETCH (2 cycles total).
  - HLT / illegal with ILLEGAL_HALTS=1: Buff_PC=1 -> HALT.
  - B / BCOND / JR: -> EXEC.
  - All others: -> EXEC.
- EXEC:
  - ALU/ALUI/CMP: Flag=1, Buff_PSW=1, ALUop=func[0] (ALUI/LDR/STR: ALUop=0).
  - B: Jump=01, Buff_PC=1 -> FETCH.
  - JR: Jump=10, Buff_PC=1 -> FETCH.
  - BCOND: Branch = condition(PSW_NZC sampled this cycle), Buff_PC=1 -> FETCH. Branch-class instructions take 3 cycles.
  - Others: -> MEM.
- MEM:
  - LDR: MEMresource=1.
  - STR: MEMresource=1, WE_MEM=1.
  - LHI/LLI: ALUorNot=1, LIorMOV=0.
  - All others: no strobes. -> WB.
- WB: Buff_PC=1 always, then -> FETCH (5 cycles total).
  - LDR: WBresource=1, WE_RF=1, PCplus1orWB=1.
  - LHI/LLI/ALU/ALUI: WBresource=0, WE_RF=1, PCplus1orWB=1.
  - STR/CMP: WE_RF=0.
- HALT: done=1 and all strobes 0. Only Rst leaves HALT.
- Invariants:
  - At most one of WE_RF, WE_MEM is high per cycle.
  - Buff_PC is high exactly once per instruction.
  - A CMP immediately followed by BCOND sees the updated PSW, because the PSW is written in EXEC at least 3 cycles before it is sampled.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode and func localparams;
  - state encodings;
  - Jump encodings (JMP_NONE, JMP_IMM, JMP_REG);
  - PSW bit indices.
- Sub-module multicycle_ctrl_decode: combinational. Maps (opcode, func) to an op-class bundle: is_load, is_store, is_li, is_alu, writes_rf, sets_flag, is_branch, is_sys, illegal. The FSM consumes only this bundle.

Test Plan:
- Reset, then LLI (00010): 5 cycles.
  - FETCH Buff_MEMIns=1; DECODE LI=0; MEM ALUorNot=1, LIorMOV=0; WB WE_RF=1, PCplus1orWB=1, Buff_PC=1.
  - WE_RF is high in exactly one cycle.
- LDR (00011):
  - DECODE oprandB=1; MEM MEMresource=1, WE_MEM=0; WB WBresource=1, WE_RF=1.
  - Next FETCH occurs on the 6th edge.
- CMP then BCOND func 00:
  - With PSW_NZC=3'b010: Branch=1 and Buff_PC=1 in the BCOND EXEC cycle.
  - Repeat with PSW_NZC=3'b000: Branch=0 and Buff_PC=1.
- OUTR (00000/00) then HLT (00000/01):
  - OUTR takes 2 cycles.
  - HLT: done=1 on the cycle after its DECODE and stays 1 for 20 cycles with all strobes 0.
- Assert Rst=0 during the MEM cycle of STR:
  - All outputs, including WE_MEM, drop to 0 asynchronously; done=0.
  - FETCH resumes on the first edge after release.
- Illegal opcode 11111:
  - ILLEGAL_HALTS=1: done=1.
  - ILLEGAL_HALTS=0: Buff_PC=1 in DECODE, then FETCH.
